fft_r2_engine: RTL and testbench

- Parametrised single-butterfly, in-place radix-2 DIT FFT/IFFT engine for N = 2^LOG2N complex points. Next generation of the fixed 2048-point core.
- Accepts one frame of natural-order samples on a valid/ready stream and stores it bit-reversed in an internal dual-port buffer.
- Runs LOG2N stages against an external twiddle ROM, then streams the spectrum out in natural order with backpressure.
- Adds inverse mode, handshakes, a status output and generic widths.

---
 rtl/fft_pkg.sv | 36 +++
 rtl/fft_r2_butterfly.sv | 67 ++++++
 rtl/fft_r2_engine.sv | 191 +++++++++++++++++++
 tb/tb_fft_r2_engine.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// fft_pkg: shared definitions for the radix-2 FFT engine.
//   state_t      FSM state encoding (also driven out on the engine's state port)
//   bitrev()     reverses the low nbits of an index
//   rnd_const()  round-half-up constant added before the Q(TW_W-2) shift
//   calc_out_w() full-growth word width: no overflow for N-point transform
package fft_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RD     = 3'd2,
    MUL    = 3'd3,
    WR     = 3'd4,
    UNLOAD = 3'd5
  } state_t;

  function automatic int bitrev(input int v, input int nbits);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if (i < nbits) r = (r << 1) | ((v >> i) & 1);
    end
    return r;
  endfunction

  // Half of one LSB after the shift by TW_W-2.
  function automatic int rnd_const(input int tw_w);
    return 1 << (tw_w - 3);
  endfunction

  // One bit of growth per stage plus one for the complex-multiply headroom.
  function automatic int calc_out_w(input int data_w, input int log2n);
    return data_w + log2n + 1;
  endfunction

endpackage

// File: rtl/fft_r2_butterfly.sv
// fft_r2_butterfly: radix-2 DIT butterfly datapath.
//   clk          clock
//   vld_p1       high in the multiply cycle; captures the rounded product
//   inv          conjugate the twiddle (inverse transform)
//   a_r/a_i      upper operand A (held stable through the write cycle)
//   b_r/b_i      lower operand B, multiplied by the twiddle
//   tw_r/tw_i    twiddle, Q(TW_W-2)
//   sum_*/diff_* A + B*W and A - B*W, combinational from the product register
module fft_r2_butterfly
  import fft_pkg::*;
#(
  parameter int OUT_W = 20,
  parameter int TW_W  = 8
) (
  input  logic                    clk,
  input  logic                    vld_p1,
  input  logic                    inv,
  input  logic signed [OUT_W-1:0] a_r,
  input  logic signed [OUT_W-1:0] a_i,
  input  logic signed [OUT_W-1:0] b_r,
  input  logic signed [OUT_W-1:0] b_i,
  input  logic signed [TW_W-1:0]  tw_r,
  input  logic signed [TW_W-1:0]  tw_i,
  output logic signed [OUT_W-1:0] sum_r,
  output logic signed [OUT_W-1:0] sum_i,
  output logic signed [OUT_W-1:0] diff_r,
  output logic signed [OUT_W-1:0] diff_i
);

  // One extra twiddle bit so negating the most negative code cannot wrap.
  localparam int TWE = TW_W + 1;
  localparam int PW  = OUT_W + TW_W + 2;

  function automatic logic signed [OUT_W-1:0] round_q(input logic signed [PW-1:0] v);
    logic signed [PW-1:0] r;
    r = (v + PW'(rnd_const(TW_W))) >>> (TW_W - 2);
    return OUT_W'(r);
  endfunction

  logic signed [TWE-1:0]   wr_e;
  logic signed [TWE-1:0]   wi_e;
  logic signed [PW-1:0]    pr;
  logic signed [PW-1:0]    pi;
  logic signed [OUT_W-1:0] t_r_p2;
  logic signed [OUT_W-1:0] t_i_p2;

  always_comb begin
    wr_e = TWE'(tw_r);
    wi_e = inv ? -TWE'(tw_i) : TWE'(tw_i);
    pr   = PW'(b_r) * PW'(wr_e) - PW'(b_i) * PW'(wi_e);
    pi   = PW'(b_r) * PW'(wi_e) + PW'(b_i) * PW'(wr_e);
  end

  // p1 -> p2: rounded product register
  always_ff @(posedge clk) begin
    if (vld_p1) begin
      t_r_p2 <= round_q(pr);
      t_i_p2 <= round_q(pi);
    end
  end

  assign sum_r  = a_r + t_r_p2;
  assign sum_i  = a_i + t_i_p2;
  assign diff_r = a_r - t_r_p2;
  assign diff_i = a_i - t_i_p2;

endmodule

// File: rtl/fft_r2_engine.sv
// fft_r2_engine: in-place radix-2 DIT FFT/IFFT, one butterfly every 3 cycles.
//   clk, rst              clock, synchronous active-low reset
//   inv                   inverse transform, captured with the first sample
//   in_valid/in_ready     natural-order input stream, in_r/in_i signed DATA_W
//   tw_addr, tw_r/tw_i    external registered twiddle ROM, W_N^k = exp(-j2pik/N)
//   out_valid/out_ready   natural-order output stream with backpressure
//   out_r/out_i, out_idx  output bin (signed OUT_W) and its index
//   busy, state           status: busy outside IDLE, raw FSM encoding
module fft_r2_engine
  import fft_pkg::*;
#(
  parameter int LOG2N  = 11,
  parameter int DATA_W = 8,
  parameter int TW_W   = 8,
  parameter int OUT_W  = calc_out_w(DATA_W, LOG2N)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    inv,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [DATA_W-1:0] in_r,
  input  logic signed [DATA_W-1:0] in_i,
  output logic [LOG2N-2:0]        tw_addr,
  input  logic signed [TW_W-1:0]  tw_r,
  input  logic signed [TW_W-1:0]  tw_i,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_r,
  output logic signed [OUT_W-1:0] out_i,
  output logic [LOG2N-1:0]        out_idx,
  output logic                    busy,
  output logic [2:0]              state
);

  localparam int N  = 1 << LOG2N;
  localparam int BW = LOG2N - 1;
  localparam logic [LOG2N-1:0] LAST_IDX = '1;
  localparam logic [BW-1:0]    LAST_BF  = '1;

  state_t            st;
  logic [LOG2N-1:0]  cnt;
  logic [3:0]        s;
  logic [BW-1:0]     b;
  logic              inv_q;

  logic signed [OUT_W-1:0] memory_r [N];
  logic signed [OUT_W-1:0] memory_i [N];

  logic signed [OUT_W-1:0] a_r_p1, a_i_p1, b_r_p1, b_i_p1;
  logic signed [OUT_W-1:0] sum_r, sum_i, diff_r, diff_i;

  logic [BW-1:0]     hmask, j, g, b_inc, tw_next;
  logic [LOG2N-1:0]  p, q, half, ld_addr;
  logic              vld_p1;

  // Butterfly addressing: within a group of 2*half points, j selects the pair.
  always_comb begin
    hmask   = BW'((1 << s) - 1);
    j       = b & hmask;
    g       = b >> s;
    half    = LOG2N'(1) << s;
    p       = ({g, 1'b0} << s) | LOG2N'(j);
    q       = p | half;
    b_inc   = b + 1'b1;
    tw_next = (b_inc & hmask) << (4'(BW) - s);
    ld_addr = LOG2N'(bitrev(int'(cnt), LOG2N));
  end

  assign vld_p1 = (st == MUL);
  assign state  = st;

  // The buffer is quiet during UNLOAD, so a direct read holds steady under stalls.
  assign out_r = out_valid ? memory_r[out_idx] : '0;
  assign out_i = out_valid ? memory_i[out_idx] : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      st        <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      tw_addr   <= '0;
      out_idx   <= '0;
      cnt       <= '0;
      s         <= '0;
      b         <= '0;
      inv_q     <= 1'b0;
    end else begin
      case (st)
        IDLE: begin
          st       <= LOAD;
          in_ready <= 1'b1;
          busy     <= 1'b1;
          cnt      <= '0;
        end
        LOAD: begin
          if (in_valid && in_ready) begin
            if (cnt == '0) inv_q <= inv;
            cnt <= cnt + 1'b1;
            if (cnt == LAST_IDX) begin
              st       <= RD;
              in_ready <= 1'b0;
              s        <= '0;
              b        <= '0;
              tw_addr  <= '0;
            end
          end
        end
        RD:  st <= MUL;
        MUL: st <= WR;
        WR: begin
          if (b == LAST_BF) begin
            b       <= '0;
            tw_addr <= '0;
            if (s == 4'(LOG2N - 1)) begin
              st        <= UNLOAD;
              out_valid <= 1'b1;
              out_idx   <= '0;
            end else begin
              s  <= s + 4'd1;
              st <= RD;
            end
          end else begin
            b       <= b_inc;
            tw_addr <= tw_next;
            st      <= RD;
          end
        end
        UNLOAD: begin
          if (out_ready) begin
            if (out_idx == LAST_IDX) begin
              st        <= IDLE;
              out_valid <= 1'b0;
              busy      <= 1'b0;
              out_idx   <= '0;
            end else begin
              out_idx <= out_idx + 1'b1;
            end
          end
        end
        default: begin
          st        <= IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  // p0 -> p1: sample load, operand fetch in RD, in-place writeback in WR
  always_ff @(posedge clk) begin
    if (st == LOAD && in_valid && in_ready) begin
      memory_r[ld_addr] <= OUT_W'(in_r);
      memory_i[ld_addr] <= OUT_W'(in_i);
    end
    if (st == RD) begin
      a_r_p1 <= memory_r[p];
      a_i_p1 <= memory_i[p];
      b_r_p1 <= memory_r[q];
      b_i_p1 <= memory_i[q];
    end
    if (st == WR) begin
      memory_r[p] <= sum_r;
      memory_i[p] <= sum_i;
      memory_r[q] <= diff_r;
      memory_i[q] <= diff_i;
    end
  end

  fft_r2_butterfly #(
    .OUT_W (OUT_W),
    .TW_W  (TW_W)
  ) u_bfly (
    .clk    (clk),
    .vld_p1 (vld_p1),
    .inv    (inv_q),
    .a_r    (a_r_p1),
    .a_i    (a_i_p1),
    .b_r    (b_r_p1),
    .b_i    (b_i_p1),
    .tw_r   (tw_r),
    .tw_i   (tw_i),
    .sum_r  (sum_r),
    .sum_i  (sum_i),
    .diff_r (diff_r),
    .diff_i (diff_i)
  );

endmodule

// File: tb/tb_fft_r2_engine.sv
// tb_fft_r2_engine: 8-point engine against a textbook Cooley-Tukey model
// with the same Q6 round-half-up twiddle products, plus literal spectra.
module tb_fft_r2_engine;

  localparam int LOG2N  = 3;
  localparam int N      = 8;
  localparam int DATA_W = 8;
  localparam int TW_W   = 8;
  localparam int OUT_W  = 12;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic inv = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic signed [DATA_W-1:0] in_r = '0;
  logic signed [DATA_W-1:0] in_i = '0;
  logic in_ready, out_valid, busy;
  logic [LOG2N-2:0] tw_addr;
  logic signed [TW_W-1:0] tw_r, tw_i;
  logic signed [OUT_W-1:0] out_r, out_i;
  logic [LOG2N-1:0] out_idx;
  logic [2:0] state;

  int errors = 0;
  int checks = 0;

  // Exact Q6 ROM for N=8: 64 = 1.0, 45 ~ 0.707.
  int rom_r [4] = '{64, 45, 0, -45};
  int rom_i [4] = '{0, -45, -64, -45};

  int     x_r [N];
  int     x_i [N];
  longint exp_r [N];
  longint exp_i [N];

  bit rdy_rand = 1'b0;
  bit gap_rand = 1'b0;
  int bins_seen = 0;
  int exp_idx = 0;
  int comp_cycles = 0;
  int ir_phase = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    tw_r <= TW_W'(rom_r[tw_addr]);
    tw_i <= TW_W'(rom_i[tw_addr]);
  end

  fft_r2_engine #(
    .LOG2N  (LOG2N),
    .DATA_W (DATA_W),
    .TW_W   (TW_W),
    .OUT_W  (OUT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .inv       (inv),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_r      (in_r),
    .in_i      (in_i),
    .tw_addr   (tw_addr),
    .tw_r      (tw_r),
    .tw_i      (tw_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_r     (out_r),
    .out_i     (out_i),
    .out_idx   (out_idx),
    .busy      (busy),
    .state     (state)
  );

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int rev3(input int v);
    return ((v & 1) << 2) | (v & 2) | ((v >> 2) & 1);
  endfunction

  // Iterative DIT FFT over bit-reversed input, twiddle W_N^(k*N/len).
  task automatic model_fft(input bit inv_m);
    longint ar [N];
    longint ai [N];
    longint wr, wi, pr, pi, tr, ti;
    int lo, hi, widx;
    for (int n = 0; n < N; n++) begin
      ar[rev3(n)] = x_r[n];
      ai[rev3(n)] = x_i[n];
    end
    for (int len = 2; len <= N; len = len * 2) begin
      for (int base = 0; base < N; base += len) begin
        for (int k = 0; k < len / 2; k++) begin
          lo   = base + k;
          hi   = lo + len / 2;
          widx = k * (N / len);
          wr   = rom_r[widx];
          wi   = inv_m ? -rom_i[widx] : rom_i[widx];
          pr   = ar[hi] * wr - ai[hi] * wi;
          pi   = ar[hi] * wi + ai[hi] * wr;
          tr   = (pr + 32) >>> 6;
          ti   = (pi + 32) >>> 6;
          ar[hi] = ar[lo] - tr;
          ai[hi] = ai[lo] - ti;
          ar[lo] = ar[lo] + tr;
          ai[lo] = ai[lo] + ti;
        end
      end
    end
    for (int n = 0; n < N; n++) begin
      exp_r[n] = ar[n];
      exp_i[n] = ai[n];
    end
  endtask

  // Output monitor: one check set on every cycle a bin is presented.
  always @(negedge clk) begin
    if (state == 3'd2 || state == 3'd3 || state == 3'd4) comp_cycles++;
    if (ir_phase == 1) begin
      chk("in_ready_low_after_last_bin", longint'(in_ready), 0);
      chk("idle_after_last_bin", longint'(state), 0);
      ir_phase = 2;
    end else if (ir_phase == 2) begin
      chk("in_ready_rises_2_cycles_after", longint'(in_ready), 1);
      ir_phase = 0;
    end
    if (out_valid) begin
      chk("out_idx_order", longint'(out_idx), exp_idx);
      chk("bin_re", longint'(out_r), exp_r[exp_idx]);
      chk("bin_im", longint'(out_i), exp_i[exp_idx]);
      if (out_ready) begin
        bins_seen++;
        if (exp_idx == N - 1) begin
          exp_idx = 0;
          ir_phase = 1;
        end else begin
          exp_idx++;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic load_frame(input bit inv_in);
    int n;
    int guard;
    n = 0;
    guard = 0;
    inv = inv_in;
    comp_cycles = 0;
    bins_seen = 0;
    exp_idx = 0;
    while (n < N && guard < 500) begin
      @(negedge clk);
      guard++;
      if (gap_rand && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_r = DATA_W'(x_r[n]);
        in_i = DATA_W'(x_i[n]);
      end
      if (in_valid && in_ready) n++;
    end
    chk("load_samples_accepted", n, N);
    @(negedge clk);
    in_valid = 1'b0;
    inv = 1'b0;
  endtask

  task automatic wait_frame(input string name);
    int guard;
    guard = 0;
    while (bins_seen < N && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    chk({name, "_compute_cycles"}, comp_cycles, 36);
    repeat (4) @(negedge clk);
    chk({name, "_bins"}, bins_seen, N);
  endtask

  task automatic set_random();
    for (int n = 0; n < N; n++) begin
      x_r[n] = int'($urandom_range(0, 200)) - 100;
      x_i[n] = int'($urandom_range(0, 200)) - 100;
    end
  endtask

  initial begin
    int m;
    int g;

    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_state", longint'(state), 0);
    chk("rst_in_ready", longint'(in_ready), 0);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_tw_addr", longint'(tw_addr), 0);
    chk("rst_out_idx", longint'(out_idx), 0);
    chk("rst_out_r", longint'(out_r), 0);
    chk("rst_out_i", longint'(out_i), 0);
    rst = 1'b1;

    // Impulse
    for (int n = 0; n < N; n++) begin x_r[n] = 0; x_i[n] = 0; end
    x_r[0] = 10;
    model_fft(1'b0);
    chk("model_impulse_X0", exp_r[0], 10);
    chk("model_impulse_X5", exp_r[5], 10);
    chk("model_impulse_X3i", exp_i[3], 0);
    load_frame(1'b0);
    @(negedge clk);
    chk("busy_in_compute", longint'(busy), 1);
    wait_frame("impulse");

    // DC
    for (int n = 0; n < N; n++) begin x_r[n] = 5; x_i[n] = 0; end
    model_fft(1'b0);
    chk("model_dc_X0", exp_r[0], 40);
    chk("model_dc_X1", exp_r[1], 0);
    chk("model_dc_X7", exp_r[7], 0);
    load_frame(1'b0);
    wait_frame("dc");

    // Single tone x[1]=(64,0), forward
    for (int n = 0; n < N; n++) begin x_r[n] = 0; x_i[n] = 0; end
    x_r[1] = 64;
    model_fft(1'b0);
    chk("model_tone_X0r", exp_r[0], 64);
    chk("model_tone_X2i", exp_i[2], -64);
    chk("model_tone_X4r", exp_r[4], -64);
    chk("model_tone_X6i", exp_i[6], 64);
    chk("model_tone_X1r", exp_r[1], 45);
    chk("model_tone_X1i", exp_i[1], -45);
    load_frame(1'b0);
    wait_frame("tone_fwd");

    // Same tone, inverse
    model_fft(1'b1);
    chk("model_inv_X2i", exp_i[2], 64);
    chk("model_inv_X6i", exp_i[6], -64);
    chk("model_inv_X1i", exp_i[1], 45);
    load_frame(1'b1);
    wait_frame("tone_inv");

    // Random data, input gaps and output backpressure
    gap_rand = 1'b1;
    rdy_rand = 1'b1;
    set_random();
    model_fft(1'b0);
    load_frame(1'b0);
    wait_frame("random_fwd");
    set_random();
    model_fft(1'b1);
    load_frame(1'b1);
    wait_frame("random_inv");
    gap_rand = 1'b0;

    // Reset during the first MUL of stage 1, then a clean frame
    set_random();
    model_fft(1'b0);
    load_frame(1'b0);
    m = 0;
    g = 0;
    while (m < 5 && g < 200) begin
      @(negedge clk);
      g++;
      if (state == 3'd3) m++;
    end
    chk("abort_reached_stage1_mul", m, 5);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_state_idle", longint'(state), 0);
    chk("abort_out_valid", longint'(out_valid), 0);
    chk("abort_busy", longint'(busy), 0);
    rst = 1'b1;
    set_random();
    model_fft(1'b0);
    load_frame(1'b0);
    wait_frame("after_abort");
    rdy_rand = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
